// File: rtl/checksum_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : checksum_calc / checksum_arbiter
//  Description : Round-robin scheduler that shares one 16-bit one's-complement
//                checksum accumulator between NUM_REQ packet-building
//                requesters and returns the tagged result over valid/ready.
//  Ports (checksum_arbiter):
//    i_clk, i_rst          clock, synchronous active-high reset
//    i_req  / o_gnt        per-requester request, one-hot grant
//    i_data / i_valid /    per-requester 32-bit word stream (slice k belongs
//    i_last / o_ready      to requester k); only the granted o_ready can rise
//    o_csum / o_csum_id /  result, owning requester index, result valid,
//    o_csum_valid /        and sink accept
//    i_csum_ready
//    o_busy                high whenever the scheduler is not idle
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// checksum_calc: accumulates (word[31:16] + word[15:0]) mod 2^32 per enabled
// beat and presents the folded, inverted 16-bit checksum of the running sum.
// ----------------------------------------------------------------------------
module checksum_calc (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic [31:0] i_data,
  output logic [15:0] o_checksum
);

  logic [31:0] sum_q;
  logic [31:0] sum_d;
  logic [15:0] w_fold;

  always_comb begin
    sum_d = sum_q;
    if (i_clear) begin
      sum_d = '0;
    end else if (i_enable) begin
      sum_d = sum_q + {16'h0000, i_data[31:16]} + {16'h0000, i_data[15:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  // Single fold only: a carry out of this add is deliberately discarded.
  assign w_fold     = sum_q[15:0] + sum_q[31:16];
  assign o_checksum = ~w_fold;

endmodule

// ----------------------------------------------------------------------------
// checksum_arbiter: top level
// ----------------------------------------------------------------------------
module checksum_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  output logic [NUM_REQ-1:0]   o_gnt,
  input  logic [NUM_REQ*32-1:0] i_data,
  input  logic [NUM_REQ-1:0]   i_valid,
  input  logic [NUM_REQ-1:0]   i_last,
  output logic [NUM_REQ-1:0]   o_ready,
  output logic [15:0]          o_csum,
  output logic [ID_W-1:0]      o_csum_id,
  output logic                 o_csum_valid,
  input  logic                 i_csum_ready,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FEED   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [ID_W:0]      c_NUM_REQ = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]    c_LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] c_ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t            state_q;
  logic [ID_W-1:0]   gnt_id_q;
  logic [ID_W-1:0]   rr_ptr_q;

  logic [31:0]       w_words [NUM_REQ];
  logic [ID_W:0]     w_idx;
  logic [ID_W-1:0]   w_sel;
  logic [ID_W-1:0]   w_rr_next;
  logic              w_clear;
  logic              w_enable;
  logic              w_last_beat;
  logic [15:0]       w_checksum;

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign w_words[k] = i_data[32*k +: 32];
    end
  endgenerate

  // Round-robin pick: scan from the highest offset down so the last hit
  // written is the first set bit at or after rr_ptr (with wrap-around).
  always_comb begin
    w_sel = rr_ptr_q;
    w_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (w_idx >= c_NUM_REQ) begin
        w_idx = w_idx - c_NUM_REQ;
      end
      if (i_req[w_idx[ID_W-1:0]]) begin
        w_sel = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_rr_next   = (gnt_id_q == c_LAST_ID) ? '0 : gnt_id_q + ID_W'(1);
  assign w_clear     = (state_q == S_CLEAR);
  assign w_enable    = (state_q == S_FEED) && i_valid[gnt_id_q];
  assign w_last_beat = w_enable && i_last[gnt_id_q];

  // Ready depends only on state and grant index, never on i_valid.
  always_comb begin
    o_ready = '0;
    if (state_q == S_FEED) begin
      o_ready[gnt_id_q] = 1'b1;
    end
  end

  checksum_calc u_calc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_clear),
    .i_enable   (w_enable),
    .i_data     (w_words[gnt_id_q]),
    .o_checksum (w_checksum)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      gnt_id_q     <= '0;
      rr_ptr_q     <= '0;
      o_gnt        <= '0;
      o_csum       <= '0;
      o_csum_id    <= '0;
      o_csum_valid <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|i_req) begin
            gnt_id_q <= w_sel;
            o_gnt    <= c_ONE << w_sel;
            o_busy   <= 1'b1;
            state_q  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          state_q <= S_FEED;
        end
        S_FEED: begin
          if (w_last_beat) begin
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Final beat has landed in the accumulator by now.
          o_csum       <= w_checksum;
          o_csum_id    <= gnt_id_q;
          o_csum_valid <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          if (i_csum_ready) begin
            rr_ptr_q     <= w_rr_next;
            o_gnt        <= '0;
            o_csum_valid <= 1'b0;
            o_busy       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
